// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and encodings for the load/store unit.
//   state_e      : controller states (IDLE, BUSY, DONE)
//   MEM_*        : decoder access request encoding (mem_op)
//   F3_*         : access size/sign encoding (funct3)
//   f3_legal     : funct3 is one of b/h/w/bu/hu
//   f3_misaligned: address low bits do not match the natural alignment
//   f3_align     : low address bits forced to the naturally aligned lane
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering shared by the load and store paths.
//   funct3     in  3   access size/sign
//   lane       in  2   byte offset within the word
//   wdata      in  32  store data (rs2)
//   rdata      in  32  read word from memory
//   be         out 4   byte enables for the addressed lane(s)
//   wdata_lane out 32  store data replicated across all lanes
//   rdata_ext  out 32  addressed lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{lane, 3'b000} +: 8];
  assign rhalf = rdata[{lane[1], 4'b0000} +: 16];

  // funct3[2] marks the unsigned variants, so it suppresses the sign fill.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7] & ~funct3[2]}}, rbyte};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {lane[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15] & ~funct3[2]}}, rhalf};
      end
      F3_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller (IDLE -> BUSY -> DONE).
// Parameter TIMEOUT_CYC: BUSY cycles without dmem_ack before err_bus is reported.
// Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned h/w accesses complete at once
// with err_misalign and never reach memory; when undefined, the low address bits are
// forced to the natural lane and only an illegal funct3 raises err_misalign.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_op, funct3, addr,    request from the decoder / ALU / rs2
//   wdata
//   stall, done, rdata_out,  pipeline handshake and load result
//   err_misalign, err_bus
//   dmem_req, dmem_we,       data memory request side
//   dmem_addr, dmem_be,
//   dmem_wdata
//   dmem_ack, dmem_rdata     data memory response side
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e        state, state_nxt;
  logic          is_store_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] cnt_q;
  logic          err_mis_q, err_bus_q;

  logic          access, bad_req, timeout, busy;
  logic [1:0]    lane_in;
  logic [3:0]    be;
  logic [31:0]   wdata_lane, rdata_ext;

  // Gated by rst so stall cannot follow mem_op while reset holds outputs low.
  assign access = !rst && ((mem_op == MEM_LOAD) || (mem_op == MEM_STORE));

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req = !f3_legal(funct3) || f3_misaligned(funct3, addr[1:0]);
  assign lane_in = addr[1:0];
`else
  assign bad_req = !f3_legal(funct3);
  assign lane_in = f3_align(funct3, addr[1:0]);
`endif

  // Counter holds the number of completed ack-less BUSY cycles; the last allowed one
  // is the cycle in which it equals TIMEOUT_CYC-1.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign busy    = (state == ST_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    dmem_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          stall     = 1'b1;
          state_nxt = bad_req ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // mem_op is deliberately ignored: the stalled instruction is still presented here.
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      cnt_q      <= '0;
      err_mis_q  <= 1'b0;
      err_bus_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            is_store_q <= (mem_op == MEM_STORE);
            addr_q     <= {addr[31:2], lane_in};
            wdata_q    <= wdata;
            f3_q       <= funct3;
            cnt_q      <= '0;
            err_mis_q  <= bad_req;
            err_bus_q  <= 1'b0;
            rdata_q    <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack)     rdata_q   <= is_store_q ? '0 : rdata_ext;
          else if (timeout) err_bus_q <= 1'b1;
          else              cnt_q     <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Works from the captured request so all dmem_* outputs stay constant during BUSY.
  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign dmem_we      = busy & is_store_q;
  assign dmem_addr    = busy ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_be      = busy ? be : '0;
  assign dmem_wdata   = busy ? wdata_lane : '0;
  assign rdata_out    = done ? rdata_q : '0;
  assign err_misalign = done & err_mis_q;
  assign err_bus      = done & err_bus_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed bench for lsu_ctrl.
// A transaction-level model derives the expected memory request and result from the
// access rules; a negedge compare process checks the DUT every cycle. A second DUT
// with TIMEOUT_CYC=4 covers the bus-timeout path.
module tb_lsu_ctrl;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        err_mis;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk, rst;
  logic [1:0]  mem_op, mem_op_t;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, dmem_rdata;
  logic        dmem_ack;

  logic        stall, done, err_misalign, err_bus, dmem_req, dmem_we;
  logic [31:0] rdata_out, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  logic        stall_t, done_t, err_misalign_t, err_bus_t, dmem_req_t, dmem_we_t;
  logic [31:0] rdata_out_t, dmem_addr_t, dmem_wdata_t;
  logic [3:0]  dmem_be_t;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle expectations read by the compare process.
  logic        chk_en;
  logic        exp_stall, exp_done, exp_req, exp_we, exp_emis, exp_ebus;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  // Observations for the literal pins.
  int          obs_stall_n, obs_done_n;
  logic        obs_req_seen, obs_we, obs_emis, obs_ebus;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata_out(rdata_out), .err_misalign(err_misalign),
    .err_bus(err_bus), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst(rst), .mem_op(mem_op_t), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall_t), .done(done_t), .rdata_out(rdata_out_t), .err_misalign(err_misalign_t),
    .err_bus(err_bus_t), .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_addr(dmem_addr_t),
    .dmem_be(dmem_be_t), .dmem_wdata(dmem_wdata_t), .dmem_ack(1'b0), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Access rules: size from funct3, natural alignment, lane = address mod 4.
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t        e;
    int unsigned nbytes, off, v, lim;
    logic [31:0] ea;
    e = '0;
    case (f3)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      3'b010:         nbytes = 4;
      default:        nbytes = 0;
    endcase
    if (nbytes == 0) begin
      e.err_mis = 1'b1;
      return e;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % nbytes != 0) begin
      e.err_mis = 1'b1;
      return e;
    end
    ea = a;
`else
    ea = a - (a % nbytes);
`endif
    e.req   = 1'b1;
    e.we    = (op == OP_STORE);
    off     = ea % 4;
    e.addr  = ea - off;
    e.be    = 4'(((1 << nbytes) - 1) << off);
    e.wdata = (nbytes == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (nbytes == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    if (!e.we) begin
      if (nbytes == 4) e.rdata = rd;
      else begin
        lim = 32'd1 << (8 * nbytes);
        v   = (rd >> (8 * off)) % lim;
        if (!f3[2] && v >= lim / 2) v = v - lim;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
      if (exp_req) begin
        check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (exp_done) begin
        check("rdata_out", rdata_out, exp_rdata);
        check("err_misalign", {31'b0, err_misalign}, {31'b0, exp_emis});
        check("err_bus", {31'b0, err_bus}, {31'b0, exp_ebus});
      end
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_emis = 1'b0; exp_ebus = 1'b0; exp_addr = '0; exp_be = '0;
    exp_wdata = '0; exp_rdata = '0;
  endtask

  task automatic clear_obs();
    obs_stall_n = 0; obs_done_n = 0; obs_req_seen = 1'b0; obs_we = 1'b0;
    obs_emis = 1'b0; obs_ebus = 1'b0; obs_addr = '0; obs_wdata = '0;
    obs_rdata = '0; obs_be = '0;
  endtask

  // One cycle: observe mid-cycle, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (stall) obs_stall_n++;
    if (done) begin
      obs_done_n++;
      obs_rdata = rdata_out;
      obs_emis  = err_misalign;
      obs_ebus  = err_bus;
    end
    if (dmem_req) begin
      obs_req_seen = 1'b1;
      obs_we       = dmem_we;
      obs_addr     = dmem_addr;
      obs_be       = dmem_be;
      obs_wdata    = dmem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  // mem_op is held through DONE, as a stalled decoder would; ack is also driven in the
  // request and DONE cycles where it must be ignored.
  task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
    exp_t e;
    e = model(op, f3, a, wd, rd);
    clear_obs();
    mem_op = op; funct3 = f3; addr = a; wdata = wd;
    dmem_rdata = ~rd; dmem_ack = 1'b1;
    set_idle_exp();
    exp_stall = 1'b1;
    step();
    if (e.req) begin
      for (int i = 0; i <= waits; i++) begin
        dmem_ack   = (i == waits);
        dmem_rdata = (i == waits) ? rd : ~rd;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = e.we;
        exp_addr = e.addr; exp_be = e.be; exp_wdata = e.wdata;
        step();
      end
    end
    dmem_ack = 1'b1; dmem_rdata = ~rd;
    set_idle_exp();
    exp_done = 1'b1; exp_rdata = e.rdata; exp_emis = e.err_mis;
    step();
    mem_op = OP_NONE; dmem_ack = 1'b0;
    set_idle_exp();
    step();
  endtask

  initial begin
    int   busy_n;
    logic got_done;

    rst = 1'b1; chk_en = 1'b0;
    mem_op = OP_NONE; mem_op_t = OP_NONE; funct3 = 3'b000;
    addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    set_idle_exp();
    clear_obs();

    #2;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_we", {31'b0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'b0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_errs", {30'b0, err_misalign, err_bus}, 32'd0);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // lb with ack in the first BUSY cycle: minimum latency.
    run_txn(OP_LOAD, 3'b000, 32'h1003, 32'h0, 32'h80AA5511, 0);
    check("lb_be", {28'b0, obs_be}, 32'h8);
    check("lb_rdata", obs_rdata, 32'hFFFFFF80);
    check("lb_stall_cycles", obs_stall_n, 2);
    check("lb_done_pulses", obs_done_n, 1);

    run_txn(OP_STORE, 3'b001, 32'h2002, 32'h1234ABCD, 32'h5A5A5A5A, 0);
    check("sh_be", {28'b0, obs_be}, 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCDABCD);
    check("sh_we", {31'b0, obs_we}, 32'd1);
    check("sh_rdata", obs_rdata, 32'd0);

    run_txn(OP_LOAD, 3'b101, 32'h3002, 32'h0, 32'hBEEF0000, 5);
    check("lhu_rdata", obs_rdata, 32'h0000BEEF);
    check("lhu_stall_cycles", obs_stall_n, 7);

    run_txn(OP_LOAD, 3'b010, 32'h4001, 32'h0, 32'h11223344, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", {31'b0, obs_emis}, 32'd1);
    check("lw_mis_noreq", {31'b0, obs_req_seen}, 32'd0);
`else
    check("lw_mis_addr", obs_addr, 32'h4000);
    check("lw_mis_be", {28'b0, obs_be}, 32'hF);
    check("lw_mis_rdata", obs_rdata, 32'h11223344);
`endif

    run_txn(OP_LOAD,  3'b001, 32'h0010, 32'h0,      32'h00008001, 1);
    check("lh_rdata", obs_rdata, 32'hFFFF8001);
    run_txn(OP_LOAD,  3'b100, 32'h0021, 32'h0,      32'h1234F0CD, 0);
    check("lbu_rdata", obs_rdata, 32'h000000F0);
    run_txn(OP_LOAD,  3'b000, 32'h0022, 32'h0,      32'h007F0000, 2);
    run_txn(OP_STORE, 3'b000, 32'h0007, 32'hFFFF0055, 32'h0,      0);
    check("sb_be", {28'b0, obs_be}, 32'h8);
    check("sb_wdata", obs_wdata, 32'h55555555);
    run_txn(OP_STORE, 3'b010, 32'h0008, 32'hCAFEF00D, 32'h0,      3);
    run_txn(OP_LOAD,  3'b001, 32'h0101, 32'h0,      32'h0000ABCD, 0);
    run_txn(OP_LOAD,  3'b011, 32'h0000, 32'h0,      32'h12345678, 0);
    check("ill_err", {31'b0, obs_emis}, 32'd1);
    check("ill_noreq", {31'b0, obs_req_seen}, 32'd0);
    run_txn(OP_STORE, 3'b110, 32'h0004, 32'h1,      32'h0,        0);

    // Reserved mem_op is a no-op.
    clear_obs();
    mem_op = OP_RSVD; dmem_ack = 1'b1;
    set_idle_exp();
    step(); step();
    mem_op = OP_NONE; dmem_ack = 1'b0;
    check("rsvd_stall", obs_stall_n, 0);

    // Timeout on the TIMEOUT_CYC=4 instance.
    funct3 = 3'b010; addr = 32'h5000; dmem_rdata = 32'hFFFFFFFF;
    mem_op_t = OP_LOAD;
    @(negedge clk);
    check("to_req_stall", {31'b0, stall_t}, 32'd1);
    @(posedge clk); #1;
    busy_n = 0; got_done = 1'b0;
    for (int i = 0; i < 12 && !got_done; i++) begin
      @(negedge clk);
      if (done_t) begin
        got_done = 1'b1;
        mem_op_t = OP_NONE;
        check("to_err_bus", {31'b0, err_bus_t}, 32'd1);
        check("to_rdata", rdata_out_t, 32'd0);
        check("to_req_low", {31'b0, dmem_req_t}, 32'd0);
        check("to_stall_low", {31'b0, stall_t}, 32'd0);
      end else if (dmem_req_t) begin
        if (busy_n == 0) check("to_addr", dmem_addr_t, 32'h5000);
        busy_n++;
      end
      @(posedge clk); #1;
    end
    mem_op_t = OP_NONE;
    check("to_done_seen", {31'b0, got_done}, 32'd1);
    check("to_busy_cycles", busy_n, 4);

    // Asynchronous reset while BUSY.
    chk_en = 1'b0;
    mem_op = OP_LOAD; funct3 = 3'b000; addr = 32'h1003; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("prerst_req", {31'b0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1; mem_op = OP_NONE;
    #1;
    check("midrst_req", {31'b0, dmem_req}, 32'd0);
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_exp();
    chk_en = 1'b1;
    run_txn(OP_LOAD, 3'b010, 32'h0040, 32'h0, 32'hDEADBEEF, 2);
    check("postrst_rdata", obs_rdata, 32'hDEADBEEF);
    check("postrst_done", obs_done_n, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
